// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the MULTU/DIVU sequencer.
package muldiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_RSV2  = 2'b10,
      OP_RSV3  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One multiply (shift-add) or divide (restoring shift-subtract) iteration.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
   import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
   input  logic             op_div,
`endif
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] p_hi,
   input  logic [WIDTH-1:0] p_lo,
   output logic [WIDTH-1:0] nxt_hi_c,
   output logic [WIDTH-1:0] nxt_lo_c
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : (WIDTH+1)'(0));
   end

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   sh;
   logic             ge;
   logic [WIDTH-1:0] diff;

   // Partial remainder never exceeds the divisor, so the trial difference fits in WIDTH bits.
   always_comb begin
      sh   = {p_hi, p_lo[WIDTH-1]};
      ge   = (sh >= {1'b0, m});
      diff = sh[WIDTH-1:0] - m;
   end
`endif

   always_comb begin
      nxt_hi_c = sum[WIDTH:1];
      nxt_lo_c = {sum[0], p_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      if (op_div) begin
         nxt_hi_c = ge ? diff : sh[WIDTH-1:0];
         nxt_lo_c = {p_lo[WIDTH-2:0], ge};
      end
`endif
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// 32-cycle iterative MULTU/DIVU unit owning the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the DIVU path; otherwise DIVU is rejected as reserved.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import muldiv_pkg::*;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] p_hi_q;
   logic [WIDTH-1:0] p_lo_q;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   op_e              op_in;
   logic             legal;
`ifdef MULDIV_DIV_EN
   logic             div_q;
`endif

   assign op_in = op_e'(op);
   assign stall = rd_req & busy;

   always_comb begin
      legal = (op_in == OP_MULTU);
`ifdef MULDIV_DIV_EN
      legal = legal | (op_in == OP_DIVU);
`endif
   end

   muldiv_step u_step (
`ifdef MULDIV_DIV_EN
      .op_div   (div_q),
`endif
      .m        (m_q),
      .p_hi     (p_hi_q),
      .p_lo     (p_lo_q),
      .nxt_hi_c (step_hi),
      .nxt_lo_c (step_lo)
   );

   // FSM, iteration counter, working registers and HI/LO; only the final RUN edge writes HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         m_q     <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q   <= 1'b0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            ST_RUN: begin
               p_hi_q <= step_hi;
               p_lo_q <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  hi    <= step_hi;
                  lo    <= step_lo;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               if (start) begin
                  if (legal) begin
                     state  <= ST_RUN;
                     busy   <= 1'b1;
                     cnt    <= '0;
                     p_hi_q <= '0;
`ifdef MULDIV_DIV_EN
                     div_q  <= (op_in == OP_DIVU);
                     m_q    <= (op_in == OP_DIVU) ? b : a;
                     p_lo_q <= (op_in == OP_DIVU) ? a : b;
`else
                     m_q    <= a;
                     p_lo_q <= b;
`endif
                  end else begin
                     illegal <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at start, compared at done.
module tb_muldiv_sequencer;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_req;
   logic        busy;
   logic        done;
   logic        stall;
   logic        illegal;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t        sb[$];
   logic [31:0] mdl_hi;
   logic [31:0] mdl_lo;
   int          n_chk;
   int          n_pass;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .rd_req  (rd_req),
      .busy    (busy),
      .done    (done),
      .stall   (stall),
      .illegal (illegal),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit op_legal(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
      return (o == 2'b00) || (o == 2'b01);
`else
      return (o == 2'b00);
`endif
   endfunction

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] p;
      if (o == 2'b00) begin
         p    = 64'(x) * 64'(y);
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == 32'd0) begin
         e.hi = x;
         e.lo = 32'hFFFF_FFFF;
      end else begin
         e.hi = x % y;
         e.lo = x / y;
      end
      return e;
   endfunction

   // Called just after a negedge; start is sampled at the next posedge (cycle 0).
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit rd, input bit poke);
      exp_t e;
      int   nbusy;
      int   nstall;
      bit   seen;
      nbusy  = 0;
      nstall = 0;
      seen   = 1'b0;
      sb.push_back(model(o, x, y));
      start  = 1'b1;
      op     = o;
      a      = x;
      b      = y;
      rd_req = rd;
      #1;
      check("pre_stall", 64'(stall), 64'(0));
      check("pre_hi", 64'(hi), 64'(mdl_hi));
      check("pre_lo", 64'(lo), 64'(mdl_lo));
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
         end
         if (poke && c == 4) begin
            start = 1'b1;
            op    = 2'b00;
            a     = 32'd3;
            b     = 32'd3;
         end
         if (poke && c == 5) start = 1'b0;
         if (done) begin
            seen = 1'b1;
            check("done_cyc", 64'(c), 64'(33));
            check("busy_cyc", 64'(nbusy), 64'(32));
            check("stall_cyc", 64'(nstall), rd ? 64'(32) : 64'(0));
            check("busy_at_done", 64'(busy), 64'(0));
            check("stall_at_done", 64'(stall), 64'(0));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("hi", 64'(hi), 64'(e.hi));
               check("lo", 64'(lo), 64'(e.lo));
               mdl_hi = e.hi;
               mdl_lo = e.lo;
            end
         end else begin
            nbusy  += int'(busy);
            nstall += int'(stall);
         end
      end
      check("done_seen", 64'(seen), 64'(1));
   endtask

   task automatic do_illegal(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start  = 1'b1;
      op     = o;
      a      = x;
      b      = y;
      rd_req = 1'b1;
      #1;
      check("ill_stall", 64'(stall), 64'(0));
      @(negedge clk);
      start = 1'b0;
      check("ill_pulse", 64'(illegal), 64'(1));
      check("ill_busy", 64'(busy), 64'(0));
      check("ill_hi", 64'(hi), 64'(mdl_hi));
      check("ill_lo", 64'(lo), 64'(mdl_lo));
      @(negedge clk);
      check("ill_clear", 64'(illegal), 64'(0));
      check("ill_busy2", 64'(busy), 64'(0));
      check("ill_done", 64'(done), 64'(0));
      rd_req = 1'b0;
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input bit rd, input bit poke);
      if (op_legal(o)) do_op(o, x, y, rd, poke);
      else             do_illegal(o, x, y);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_done", 64'(done), 64'(0));
         check("idle_busy", 64'(busy), 64'(0));
      end
   endtask

   // MULTU started at cycle 0, reset held during cycle 10; returns at the negedge of cycle 12.
   task automatic do_abort();
      exp_t dropped;
      int   ndone;
      ndone = 0;
      sb.push_back(model(2'b00, 32'd1000, 32'd1000));
      start  = 1'b1;
      op     = 2'b00;
      a      = 32'd1000;
      b      = 32'd1000;
      rd_req = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         ndone += int'(done);
         if (c == 10) begin
            check("abort_busy_pre", 64'(busy), 64'(1));
            reset = 1'b1;
         end
         if (c == 11) begin
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_hi", 64'(hi), 64'(0));
            check("abort_lo", 64'(lo), 64'(0));
            reset = 1'b0;
         end
      end
      check("abort_no_done", 64'(ndone), 64'(0));
      if (sb.size() != 0) dropped = sb.pop_back();
      mdl_hi = '0;
      mdl_lo = '0;
      @(negedge clk);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      mdl_hi = '0;
      mdl_lo = '0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      rd_req = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_illegal", 64'(illegal), 64'(0));
      check("rst_stall", 64'(stall), 64'(0));
      rd_req = 1'b0;

      run(2'b00, 32'd7, 32'd6, 1'b0, 1'b0);
      idle(2);
      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      run(2'b01, 32'd100, 32'd7, 1'b1, 1'b0);
      run(2'b01, 32'd5, 32'd0, 1'b0, 1'b0);
      idle(2);
      do_illegal(2'b11, 32'd9, 32'd9);
      do_illegal(2'b10, 32'd4, 32'd2);
      for (int i = 0; i < 3; i++) run(2'b00, $urandom, $urandom, i[0], 1'b0);
      run(2'b01, $urandom, 32'($urandom_range(1, 1000)), 1'b0, 1'b0);
      idle(1);
      do_abort();
      run(2'b00, 32'd12345, 32'd678, 1'b0, 1'b0);
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
